// File: rtl/bsg_profiler_sample_ctrl.sv
// Sampling controller for a bank of per-client event counters.
// Live counters accumulate countme strobes; on a snapshot event they are copied
// into shadow registers and restarted, and the shadow bank is then drained one
// word per handshake over a valid/ready port, tagged with a 16-bit epoch.
module bsg_profiler_sample_ctrl #(
  parameter int unsigned els_p           = 32,
  parameter int unsigned counter_width_p = 32,
  parameter int unsigned period_width_p  = 16,
  parameter int unsigned missed_width_p  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  input  logic                       clear_i,
  input  logic [period_width_p-1:0]  period_i,
  input  logic                       snap_req_i,
  input  logic [els_p-1:0]           countme_i,
  output logic                       v_o,
  output logic [$clog2(els_p)-1:0]   id_o,
  output logic [15:0]                epoch_o,
  output logic [counter_width_p-1:0] count_o,
  input  logic                       ready_i,
  output logic                       busy_o,
  output logic [missed_width_p-1:0]  missed_o
);

  localparam int unsigned IdW = $clog2(els_p);
  localparam logic [IdW-1:0] LastIdx = IdW'(els_p - 1);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                     state_q, state_d;
  logic [IdW-1:0]             idx_q, idx_d;
  logic [period_width_p-1:0]  timer_q, timer_d;
  logic [15:0]                epoch_q, epoch_d;
  logic [15:0]                tag_q, tag_d;
  logic [missed_width_p-1:0]  missed_q, missed_d;
  logic [counter_width_p-1:0] live_q   [els_p];
  logic [counter_width_p-1:0] live_d   [els_p];
  logic [counter_width_p-1:0] shadow_q [els_p];
  logic [counter_width_p-1:0] shadow_d [els_p];

  logic period_evt;
  logic snap_evt;
  logic take;
  logic drop;

  // Period timer; a period lowered below the current count fires on the next edge.
  always_comb begin
    timer_d    = timer_q;
    period_evt = 1'b0;
    if (clear_i) begin
      timer_d = '0;
    end else if (en_i && (period_i != '0)) begin
      if (timer_q >= (period_i - 1'b1)) begin
        timer_d    = '0;
        period_evt = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // clear_i suppresses any snapshot event in the same cycle.
  assign snap_evt = (period_evt | snap_req_i) & ~clear_i;

  // FSM next state: take a snapshot in IDLE, drop snapshot events while draining.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    take    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (snap_evt) begin
          take    = 1'b1;
          idx_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        drop = snap_evt;
        if (ready_i) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Live/shadow counters: a strobe in the snapshot cycle seeds the new epoch.
  always_comb begin
    for (int k = 0; k < els_p; k++) begin
      live_d[k]   = live_q[k];
      shadow_d[k] = shadow_q[k];
      if (clear_i) begin
        live_d[k] = '0;
      end else if (take) begin
        shadow_d[k] = live_q[k];
        live_d[k]   = counter_width_p'(en_i & countme_i[k]);
      end else if (en_i && countme_i[k] && (live_q[k] != '1)) begin
        live_d[k] = live_q[k] + 1'b1;
      end
    end
  end

  // Epoch tagging and saturating missed-snapshot count.
  always_comb begin
    epoch_d  = epoch_q;
    tag_d    = tag_q;
    missed_d = missed_q;
    if (take) begin
      tag_d   = epoch_q;
      epoch_d = epoch_q + 16'd1;
    end
    if (clear_i) begin
      missed_d = '0;
    end else if (drop && (missed_q != '1)) begin
      missed_d = missed_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      timer_q  <= '0;
      epoch_q  <= '0;
      tag_q    <= '0;
      missed_q <= '0;
      for (int k = 0; k < els_p; k++) begin
        live_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      epoch_q  <= epoch_d;
      tag_q    <= tag_d;
      missed_q <= missed_d;
      for (int k = 0; k < els_p; k++) begin
        live_q[k]   <= live_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  // Outputs come straight from registers so they hold steady under backpressure.
  always_comb begin
    v_o      = (state_q == StDrain);
    busy_o   = (state_q == StDrain);
    id_o     = idx_q;
    epoch_o  = tag_q;
    missed_o = missed_q;
    count_o  = v_o ? shadow_q[idx_q] : '0;
  end

endmodule

// File: tb/tb_bsg_profiler_sample_ctrl.sv
// Randomized plus directed bench for bsg_profiler_sample_ctrl, checked against
// a queue-based model of the expected drain words.
module tb_bsg_profiler_sample_ctrl;

  localparam int unsigned ElsP   = 4;
  localparam int unsigned CntW   = 4;
  localparam int unsigned PerW   = 8;
  localparam int unsigned MisW   = 3;
  localparam int          CntMax = (1 << CntW) - 1;
  localparam int          MisMax = (1 << MisW) - 1;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            en_i;
  logic            clear_i;
  logic [PerW-1:0] period_i;
  logic            snap_req_i;
  logic [ElsP-1:0] countme_i;
  logic            ready_i;
  logic            v_o;
  logic [1:0]      id_o;
  logic [15:0]     epoch_o;
  logic [CntW-1:0] count_o;
  logic            busy_o;
  logic [MisW-1:0] missed_o;

  bsg_profiler_sample_ctrl #(
    .els_p          (ElsP),
    .counter_width_p(CntW),
    .period_width_p (PerW),
    .missed_width_p (MisW)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (en_i),
    .clear_i   (clear_i),
    .period_i  (period_i),
    .snap_req_i(snap_req_i),
    .countme_i (countme_i),
    .v_o       (v_o),
    .id_o      (id_o),
    .epoch_o   (epoch_o),
    .count_o   (count_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .missed_o  (missed_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int id;
    int ep;
    int cnt;
  } word_t;

  // Reference model state.
  word_t exp_q[$];
  int    live[ElsP];
  int    timer;
  int    epoch;
  int    missed;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < ElsP; k++) live[k] = 0;
    timer  = 0;
    epoch  = 0;
    missed = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input int per, input bit req,
                            input logic [ElsP-1:0] cm, input bit rdy);
    bit    busy;
    bit    pev;
    bit    snap;
    word_t w;
    busy = (exp_q.size() != 0);
    pev  = 1'b0;
    if (clr) begin
      timer = 0;
    end else if (en && per != 0) begin
      if (timer >= per - 1) begin
        timer = 0;
        pev   = 1'b1;
      end else begin
        timer++;
      end
    end
    snap = (pev || req) && !clr;
    if (busy && rdy) void'(exp_q.pop_front());
    if (clr) begin
      for (int k = 0; k < ElsP; k++) live[k] = 0;
      missed = 0;
    end else if (snap && !busy) begin
      for (int k = 0; k < ElsP; k++) begin
        w.id  = k;
        w.ep  = epoch;
        w.cnt = live[k];
        exp_q.push_back(w);
        live[k] = (en && cm[k]) ? 1 : 0;
      end
      epoch = (epoch + 1) % 65536;
    end else begin
      if (snap && missed < MisMax) missed++;
      for (int k = 0; k < ElsP; k++)
        if (en && cm[k] && live[k] < CntMax) live[k]++;
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (exp_q.size() != 0);
    check_eq("v_o", v_o, v);
    check_eq("busy_o", busy_o, v);
    check_eq("missed_o", missed_o, missed);
    if (v) begin
      check_eq("id_o", id_o, exp_q[0].id);
      check_eq("epoch_o", epoch_o, exp_q[0].ep);
      check_eq("count_o", count_o, exp_q[0].cnt);
    end
  endtask

  // Drive one cycle of inputs at a negedge, advance the model, check at next negedge.
  task automatic cycle(input bit en, input bit clr, input int per, input bit req,
                       input logic [ElsP-1:0] cm, input bit rdy);
    en_i       = en;
    clear_i    = clr;
    period_i   = PerW'(per);
    snap_req_i = req;
    countme_i  = cm;
    ready_i    = rdy;
    model_step(en, clr, per, req, cm, rdy);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    reset_n_i  = 1'b0;
    en_i       = 1'b0;
    clear_i    = 1'b0;
    period_i   = '0;
    snap_req_i = 1'b0;
    countme_i  = '0;
    ready_i    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check_eq("rst_id", id_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_epoch", epoch_o, 0);
    check_outputs();

    // Periodic sampling with a constant strobe on client 0.
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, 10, 1'b0, 4'b0001, 1'b1);
    idle(6);

    // Saturation of client 2.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 0, 1'b0, 4'b0100, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b1);
    idle(6);

    // Backpressure: ready pattern 1,0,0,1 repeating.
    cycle(1'b1, 1'b0, 0, 1'b1, 4'b1010, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 0, 1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
    idle(2);

    // Overrun: period 3 with the sink stalled.
    cycle(1'b1, 1'b1, 3, 1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 21; i++) cycle(1'b1, 1'b0, 3, 1'b0, 4'b0001, 1'b0);
    check_eq("overrun_missed", missed_o, 6);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0, 1'b0, 4'b0001, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b1, 4'b0001, 1'b1);
    idle(6);

    // Strobe in the snapshot cycle lands in the next epoch.
    cycle(1'b1, 1'b0, 0, 1'b1, 4'b0010, 1'b1);
    idle(5);
    cycle(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b1);
    idle(5);

    // clear_i beats a simultaneous snapshot request.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0, 4'b1111, 1'b1);
    cycle(1'b1, 1'b1, 0, 1'b1, 4'b1111, 1'b1);
    check_eq("clr_snap_nodrain", v_o, 0);
    cycle(1'b0, 1'b0, 0, 1'b1, 4'b0000, 1'b1);
    idle(5);

    // Async reset in the middle of a drain.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0, 1'b0, 4'b0110, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b1);
    check_eq("pre_rst_idx", id_o, 2);
    reset_n_i = 1'b0;
    #1;
    check_eq("async_rst_v", v_o, 0);
    check_eq("async_rst_busy", busy_o, 0);
    model_reset();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0, 4'b1001, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b1);
    check_eq("post_rst_epoch", epoch_o, 0);
    idle(5);

    // Randomized traffic.
    begin
      int per;
      per = 5;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 99) == 0) per = $urandom_range(0, 12);
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, per,
              $urandom_range(0, 24) == 0, ElsP'($urandom), $urandom_range(0, 2) != 0);
      end
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
